route_collector: RTL and testbench

ROUTE_COLLECTOR -- requirements
Module: route_collector

---
 rtl/route_collector_pkg.sv | 18 +
 rtl/route_collector_uniform_det.sv | 15 +
 rtl/route_collector.sv | 159 +++++++++++++++
 tb/tb_route_collector.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/route_collector_pkg.sv
// route_collector_pkg
//   Shared defaults and FSM state encoding for the route collector.
//   WIDTH_DEF         : bits per capacitor / channel word
//   CHANNEL_NUM_DEF   : number of packed output channels
//   CAPACITOR_NUM_DEF : number of capacitor-side input words
package route_collector_pkg;

    localparam int WIDTH_DEF         = 4;
    localparam int CHANNEL_NUM_DEF   = 4;
    localparam int CAPACITOR_NUM_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/route_collector_uniform_det.sv
// uniform_det
//   Flags a word whose bits are all 0 or all 1.
//   word_in     : WIDTH-bit word under test
//   uniform_out : 1 when word_in is all-0 or all-1
module uniform_det #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] word_in,
    output logic             uniform_out
);

    // The two cases are mutually exclusive, so XOR behaves as OR here.
    assign uniform_out = (&word_in) ^ (~|word_in);

endmodule

// File: rtl/route_collector.sv
// route_collector
//   Latches a frame of capacitor words plus an enable mask, then scans the
//   capacitors one per cycle, packing enabled words into consecutive output
//   channels. Enabled words beyond the last channel are dropped and flagged
//   as overflow. The finished frame is held until downstream accepts it.
//   clk, rst_n   : clock, async active-low reset
//   cap_data_in  : CAPACITOR_NUM packed words
//   sw           : per-capacitor enable mask
//   in_valid     : input frame valid        in_ready : frame can be taken
//   data_out     : CHANNEL_NUM packed words ch_mask  : channel filled
//   ch_flag      : filled and uniform word  overflow : channels exhausted
//   out_valid    : output frame valid       out_ready: downstream accepts
//
//   state   | meaning
//   IDLE    | waiting for an input frame, in_ready high
//   SCAN    | walking capacitors 0..CAPACITOR_NUM-1, one per cycle
//   DONE    | frame complete; out_valid asserts one cycle after entry
module route_collector
    import route_collector_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int CHANNEL_NUM   = CHANNEL_NUM_DEF,
    parameter int CAPACITOR_NUM = CAPACITOR_NUM_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH*CAPACITOR_NUM-1:0] cap_data_in,
    input  logic [CAPACITOR_NUM-1:0]       sw,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [WIDTH*CHANNEL_NUM-1:0]   data_out,
    output logic [CHANNEL_NUM-1:0]         ch_mask,
    output logic [CHANNEL_NUM-1:0]         ch_flag,
    output logic                           overflow,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int CAP_IDX_W = (CAPACITOR_NUM > 1) ? $clog2(CAPACITOR_NUM) : 1;
    // Extra bit so ch_idx can hold CHANNEL_NUM ("all channels used").
    localparam int CH_IDX_W  = $clog2(CHANNEL_NUM) + 1;

    state_t                         state_q, state_d;
    logic [WIDTH*CAPACITOR_NUM-1:0] cap_q, cap_d;
    logic [CAPACITOR_NUM-1:0]       sw_q, sw_d;
    logic [CAP_IDX_W-1:0]           cap_idx_q, cap_idx_d;
    logic [CH_IDX_W-1:0]            ch_idx_q, ch_idx_d;
    logic [WIDTH*CHANNEL_NUM-1:0]   data_out_q, data_out_d;
    logic [CHANNEL_NUM-1:0]         ch_mask_q, ch_mask_d;
    logic [CHANNEL_NUM-1:0]         ch_flag_q, ch_flag_d;
    logic                           overflow_q, overflow_d;
    logic                           out_valid_q, out_valid_d;
    logic                           in_ready_q, in_ready_d;

    logic [WIDTH-1:0]               cap_word;
    logic                           cap_uniform;

    assign cap_word = cap_q[cap_idx_q*WIDTH +: WIDTH];

    uniform_det #(.WIDTH(WIDTH)) u_uniform_det (
        .word_in     (cap_word),
        .uniform_out (cap_uniform)
    );

    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        sw_d       = sw_q;
        cap_idx_d  = cap_idx_q;
        ch_idx_d   = ch_idx_q;
        data_out_d = data_out_q;
        ch_mask_d  = ch_mask_q;
        ch_flag_d  = ch_flag_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    cap_d      = cap_data_in;
                    sw_d       = sw;
                    data_out_d = '0;
                    ch_mask_d  = '0;
                    ch_flag_d  = '0;
                    overflow_d = 1'b0;
                    cap_idx_d  = '0;
                    ch_idx_d   = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (sw_q[cap_idx_q]) begin
                    if (ch_idx_q < CH_IDX_W'(CHANNEL_NUM)) begin
                        for (int j = 0; j < CHANNEL_NUM; j++) begin
                            if (ch_idx_q == CH_IDX_W'(j)) begin
                                data_out_d[j*WIDTH +: WIDTH] = cap_word;
                                ch_mask_d[j]                 = 1'b1;
                                ch_flag_d[j]                 = cap_uniform;
                            end
                        end
                        ch_idx_d = ch_idx_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                cap_idx_d = cap_idx_q + 1'b1;
                if (cap_idx_q == CAP_IDX_W'(CAPACITOR_NUM - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // out_valid lags DONE entry by one cycle, giving the
        // CAPACITOR_NUM+1 cycle accept-to-valid latency.
        out_valid_d = (state_q == ST_DONE) && (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cap_q       <= '0;
            sw_q        <= '0;
            cap_idx_q   <= '0;
            ch_idx_q    <= '0;
            data_out_q  <= '0;
            ch_mask_q   <= '0;
            ch_flag_q   <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            sw_q        <= sw_d;
            cap_idx_q   <= cap_idx_d;
            ch_idx_q    <= ch_idx_d;
            data_out_q  <= data_out_d;
            ch_mask_q   <= ch_mask_d;
            ch_flag_q   <= ch_flag_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign data_out  = data_out_q;
    assign ch_mask   = ch_mask_q;
    assign ch_flag   = ch_flag_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_route_collector.sv
// tb_route_collector
//   Directed and randomized frames for route_collector at default parameters,
//   compared against a frame-level reference model.
module tb_route_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cap_data_in;
    logic [7:0]  sw;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_out;
    logic [3:0]  ch_mask;
    logic [3:0]  ch_flag;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    route_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cap_data_in (cap_data_in),
        .sw          (sw),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_out    (data_out),
        .ch_mask     (ch_mask),
        .ch_flag     (ch_flag),
        .overflow    (overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: pack enabled words in ascending capacitor order.
    function automatic void model(input logic [7:0] s, input logic [31:0] c,
                                  output logic [15:0] d, output logic [3:0] m,
                                  output logic [3:0] f, output logic o);
        int ch;
        logic [3:0] w;
        ch = 0; d = '0; m = '0; f = '0; o = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (s[k]) begin
                if (ch < 4) begin
                    w = c[k*4 +: 4];
                    d[ch*4 +: 4] = w;
                    m[ch] = 1'b1;
                    f[ch] = (w == 4'h0) || (w == 4'hF);
                    ch++;
                end else begin
                    o = 1'b1;
                end
            end
        end
    endfunction

    task automatic run_frame(input logic [7:0] s, input logic [31:0] c,
                             input logic [15:0] e_d, input logic [3:0] e_m,
                             input logic [3:0] e_f, input logic e_o, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_idle", 64'(in_ready), 64'(1));
        sw = s; cap_data_in = c; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the captured frame must not change.
        in_valid = 1'($urandom_range(0, 1));
        sw = 8'($urandom);
        cap_data_in = $urandom;
        check("in_ready_scan", 64'(in_ready), 64'(0));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
            sw = 8'($urandom);
            cap_data_in = $urandom;
        end
        check("latency", 64'(n), 64'(9));
        check("data_out", 64'(data_out), 64'(e_d));
        check("ch_mask", 64'(ch_mask), 64'(e_m));
        check("ch_flag", 64'(ch_flag), 64'(e_f));
        check("overflow", 64'(overflow), 64'(e_o));
        in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_in_ready", 64'(in_ready), 64'(0));
            check("hold_data", {28'd0, data_out, ch_mask, ch_flag, overflow, 3'd0},
                  {28'd0, e_d, e_m, e_f, e_o, 3'd0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", 64'(out_valid), 64'(0));
        check("post_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [7:0]  rs;
        logic [31:0] rc;
        logic [15:0] md;
        logic [3:0]  mm, mf;
        logic        mo;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sw = '0; cap_data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outputs", {44'd0, data_out, ch_mask, ch_flag},
              {44'd0, 16'h0000, 4'h0, 4'h0});
        check("rst_overflow", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two enabled capacitors, sparse.
        run_frame(8'b0000_0101, 32'hB7C5_0A03, 16'h00A3, 4'b0011, 4'b0000, 1'b0, 1);
        // All enabled: first four packed, rest overflow.
        run_frame(8'hFF, 32'h8765_4321, 16'h4321, 4'hF, 4'h0, 1'b1, 0);
        // None enabled: full scan, empty frame.
        run_frame(8'h00, $urandom, 16'h0000, 4'h0, 4'h0, 1'b0, 2);
        // Uniform-word flags, held 5 cycles with in_valid high.
        run_frame(8'b1000_0011, 32'h6000_000F, 16'h060F, 4'b0111, 4'b0011, 1'b0, 5);

        // Reset while scanning capacitor 3.
        sw = 8'hFF; cap_data_in = 32'h8765_4321; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_outputs", {43'd0, data_out, ch_mask, ch_flag, overflow},
              {43'd0, 16'h0, 4'h0, 4'h0, 1'b0});
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", 64'(out_valid), 64'(0));
        end
        check("midrst_idle_ready", 64'(in_ready), 64'(1));

        // Randomized frames against the model.
        for (int t = 0; t < 25; t++) begin
            rs = 8'($urandom);
            if (t % 5 == 0) rs = 8'($urandom) | 8'($urandom);
            rc = $urandom;
            if (t % 3 == 0) rc = rc & 32'hF0F0_0FF0 | 32'h0F00_F000;
            model(rs, rc, md, mm, mf, mo);
            run_frame(rs, rc, md, mm, mf, mo, $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
